// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: IR field positions,
// instruction op codes, FSM state encoding and instruction classification.
package cpu_defs_pkg;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHL  = 5'b01000;
  localparam logic [4:0] OP_ROR  = 5'b01001;
  localparam logic [4:0] OP_ROL  = 5'b01010;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6, HALT} state_e;

  typedef enum logic [2:0] {
    CL_BINARY, CL_UNARY, CL_MULDIV, CL_NOP, CL_HALT, CL_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: return CL_BINARY;
      OP_MUL, OP_DIV:                 return CL_MULDIV;
      OP_NEG, OP_NOT:                 return CL_UNARY;
      OP_NOP:                         return CL_NOP;
      OP_HALT:                        return CL_HALT;
      default:                        return CL_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/alu_control_unit_if.sv
// Control-unit <-> datapath bundle: IR/handshake inputs and all datapath strobes.
interface alu_control_unit_if #(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPW      = 5
);
  logic [31:0]         ir;
  logic                mem_ready;
  logic                stop;
  logic                PCout, MARin, IncPC, Read, MDRin, MDRout, IRin;
  logic                Yin, Zin, Zhighout, Zlowout, HIin, LOin, PCin;
  logic [NUM_REGS-1:0] Rin;
  logic [NUM_REGS-1:0] Rout;
  logic [OPW-1:0]      opcode;
  logic                run;
  logic                illegal_op;

  modport master (
    input  ir, mem_ready, stop,
    output PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zhighout, Zlowout, HIin, LOin, PCin,
           Rin, Rout, opcode, run, illegal_op
  );

  modport slave (
    output ir, mem_ready, stop,
    input  PCout, MARin, IncPC, Read, MDRin, MDRout, IRin,
           Yin, Zin, Zhighout, Zlowout, HIin, LOin, PCin,
           Rin, Rout, opcode, run, illegal_op
  );
endinterface

// File: rtl/reg_select_decoder.sv
// Binary register index to one-hot select, all-zero when disabled.
module reg_select_decoder #(
  parameter int unsigned NUM_REGS = 16
) (
  input  logic                        en_i,
  input  logic [$clog2(NUM_REGS)-1:0] sel_i,
  output logic [NUM_REGS-1:0]         onehot_o
);
  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end
endmodule

// File: rtl/alu_control_unit.sv
// Hardwired Moore control unit sequencing fetch (T0-T2) and execute (T3-T6)
// for ALU, mul/div, nop and halt instructions.
module alu_control_unit
  import cpu_defs_pkg::*;
#(
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned OPW      = 5
) (
  input  logic                 Clock,
  input  logic                 clear,
  alu_control_unit_if.master   bus
);

  state_e         state_q, state_d;
  op_class_e      cls;
  logic [OPW-1:0] op;
  logic [3:0]     ra, rb, rc;
  logic           last_step;
  logic           rin_en, rout_en;
  logic [3:0]     rout_sel;
  logic           unused_ir;

  assign op        = bus.ir[OP_MSB:OP_LSB];
  assign ra        = bus.ir[RA_MSB:RA_LSB];
  assign rb        = bus.ir[RB_MSB:RB_LSB];
  assign rc        = bus.ir[RC_MSB:RC_LSB];
  assign unused_ir = ^bus.ir[RC_LSB-1:0];
  assign cls       = classify(op);

  // Points where an instruction is complete and stop may divert to HALT.
  assign last_step = (state_q == T6) ||
                     (state_q == T5 && cls != CL_MULDIV) ||
                     (state_q == T3 && (cls == CL_NOP || cls == CL_ILLEGAL));

  always_comb begin
    state_d = state_q;
    case (state_q)
      T0:      state_d = T1;
      T1:      state_d = bus.mem_ready ? T2 : T1;
      T2:      state_d = T3;
      T3:      state_d = (cls == CL_HALT) ? HALT :
                         last_step ? (bus.stop ? HALT : T0) : T4;
      T4:      state_d = T5;
      T5:      state_d = last_step ? (bus.stop ? HALT : T0) : T6;
      T6:      state_d = bus.stop ? HALT : T0;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!clear) state_q <= T0;
    else        state_q <= state_d;
  end

  logic uses_regs;
  assign uses_regs = (cls == CL_BINARY || cls == CL_UNARY || cls == CL_MULDIV);

  always_comb begin
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Zin        = 1'b0;
    bus.Zhighout   = 1'b0;
    bus.Zlowout    = 1'b0;
    bus.HIin       = 1'b0;
    bus.LOin       = 1'b0;
    bus.PCin       = 1'b0;
    bus.opcode     = '0;
    bus.illegal_op = 1'b0;
    rin_en         = 1'b0;
    rout_en        = 1'b0;
    rout_sel       = rb;
    if (clear) begin
      case (state_q)
        T0: begin
          bus.PCout = 1'b1;
          bus.MARin = 1'b1;
          bus.IncPC = 1'b1;
          bus.Zin   = 1'b1;
        end
        T1: begin
          bus.Read  = 1'b1;
          bus.MDRin = 1'b1;
        end
        T2: begin
          bus.Zlowout = 1'b1;
          bus.PCin    = 1'b1;
          bus.MDRout  = 1'b1;
          bus.IRin    = 1'b1;
        end
        T3: begin
          bus.Yin        = uses_regs;
          rout_en        = uses_regs;
          bus.illegal_op = (cls == CL_ILLEGAL);
        end
        T4: begin
          rout_en    = 1'b1;
          rout_sel   = (cls == CL_UNARY) ? rb : rc;
          bus.opcode = op;
          bus.Zin    = 1'b1;
        end
        T5: begin
          bus.Zlowout = 1'b1;
          bus.LOin    = (cls == CL_MULDIV);
          rin_en      = (cls != CL_MULDIV);
        end
        T6: begin
          bus.Zhighout = 1'b1;
          bus.HIin     = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.run = clear && (state_q != HALT);

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rin_dec (
    .en_i     (rin_en),
    .sel_i    (ra),
    .onehot_o (bus.Rin)
  );

  reg_select_decoder #(.NUM_REGS(NUM_REGS)) u_rout_dec (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (bus.Rout)
  );

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed vector bench for alu_control_unit: per-cycle output table plus
// cycle-count sequences for memory wait, mul, nop and illegal op.
module tb_alu_control_unit;

  logic Clock = 1'b0;
  logic clear = 1'b0;
  always #5 Clock = ~Clock;

  alu_control_unit_if #(.NUM_REGS(16), .OPW(5)) bus ();

  alu_control_unit #(.NUM_REGS(16), .OPW(5)) dut (
    .Clock (Clock),
    .clear (clear),
    .bus   (bus)
  );

  // Strobe order: PCout MARin IncPC Read MDRin MDRout IRin Yin Zin Zhighout Zlowout HIin LOin PCin
  localparam logic [13:0] S0   = 14'b00000000000000;
  localparam logic [13:0] ST0  = 14'b11100000100000;
  localparam logic [13:0] ST1  = 14'b00011000000000;
  localparam logic [13:0] ST2  = 14'b00000110001001;
  localparam logic [13:0] SYIN = 14'b00000001000000;
  localparam logic [13:0] SZIN = 14'b00000000100000;
  localparam logic [13:0] SZL  = 14'b00000000001000;
  localparam logic [13:0] SZLO = 14'b00000000001010;
  localparam logic [13:0] SZHI = 14'b00000000010100;

  localparam logic [31:0] I_AND  = 32'h28918000; // and R1,R2,R3
  localparam logic [31:0] I_MUL  = 32'h78118000; // mul Rb=R2,Rc=R3
  localparam logic [31:0] I_ILL  = 32'hF8000000;
  localparam logic [31:0] I_NOP  = 32'hD0000000;
  localparam logic [31:0] I_HALT = 32'hD8000000;
  localparam logic [31:0] I_NOT  = 32'h92480000; // not R4,R9
  localparam logic [31:0] I_DIV  = 32'h800F8000; // div Rb=R1,Rc=R15
  localparam logic [31:0] I_OR   = 32'h32B38000; // or R5,R6,R7

  typedef struct {
    int unsigned n;
    logic        clr, mr, stp;
    logic [31:0] ir;
    logic [13:0] strb;
    logic [15:0] rin, rout;
    logic [4:0]  opc;
    logic        run, ill;
  } vec_t;

  vec_t vq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(int unsigned n, logic clr, logic mr, logic stp,
                              logic [31:0] ir, logic [13:0] strb,
                              logic [15:0] rin, logic [15:0] rout,
                              logic [4:0] opc, logic run, logic ill);
    vec_t v;
    v.n = n; v.clr = clr; v.mr = mr; v.stp = stp; v.ir = ir; v.strb = strb;
    v.rin = rin; v.rout = rout; v.opc = opc; v.run = run; v.ill = ill;
    vq.push_back(v);
  endfunction

  // Fetch T0..T2 with clear high; T1 advances immediately.
  function automatic void fetch(logic [31:0] ir);
    add(1, 1, 1, 0, ir, ST0, 16'h0, 16'h0, 5'b0, 1, 0);
    add(1, 1, 1, 0, ir, ST1, 16'h0, 16'h0, 5'b0, 1, 0);
    add(1, 1, 1, 0, ir, ST2, 16'h0, 16'h0, 5'b0, 1, 0);
  endfunction

  function automatic void held(int unsigned n, logic clr, logic run);
    add(n, clr, 1, 0, 32'h0, S0, 16'h0, 16'h0, 5'b0, run, 0);
  endfunction

  function automatic logic [52:0] outs();
    return {bus.PCout, bus.MARin, bus.IncPC, bus.Read, bus.MDRin, bus.MDRout,
            bus.IRin, bus.Yin, bus.Zin, bus.Zhighout, bus.Zlowout, bus.HIin,
            bus.LOin, bus.PCin, bus.Rin, bus.Rout, bus.opcode, bus.run,
            bus.illegal_op};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_count(input string name, input logic [31:0] ir,
                           input int wait_cycles, input int exp_cycles,
                           input int exp_reads, input int exp_ills);
    int cycles, reads, ills;
    cycles = 0; reads = 0; ills = 0;
    clear = 1'b1; bus.ir = ir; bus.stop = 1'b0; bus.mem_ready = 1'b0;
    #1;
    do begin
      if (bus.Read) begin
        reads++;
        bus.mem_ready = (reads > wait_cycles);
      end
      if (bus.illegal_op) ills++;
      @(posedge Clock); #1;
      cycles++;
    end while (!bus.PCout && cycles < 40);
    check({name, "_cycles"}, 64'(cycles), 64'(exp_cycles));
    check({name, "_reads"},  64'(reads),  64'(exp_reads));
    check({name, "_illegal"}, 64'(ills),  64'(exp_ills));
  endtask

  initial begin
    bus.ir = '0; bus.mem_ready = 1'b0; bus.stop = 1'b0;

    // Reset then and R1,R2,R3
    held(2, 0, 0);
    fetch(I_AND);
    add(1, 1, 1, 0, I_AND, SYIN, 16'h0,    16'h0004, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_AND, SZIN, 16'h0,    16'h0008, 5'b00101, 1, 0);
    add(1, 1, 1, 0, I_AND, SZL,  16'h0002, 16'h0,    5'b0,     1, 0);
    // Same instruction, memory late by 3 cycles
    add(1, 1, 0, 0, I_AND, ST0, 16'h0, 16'h0, 5'b0, 1, 0);
    add(3, 1, 0, 0, I_AND, ST1, 16'h0, 16'h0, 5'b0, 1, 0);
    add(1, 1, 1, 0, I_AND, ST1, 16'h0, 16'h0, 5'b0, 1, 0);
    add(1, 1, 1, 0, I_AND, ST2, 16'h0, 16'h0, 5'b0, 1, 0);
    add(1, 1, 1, 0, I_AND, SYIN, 16'h0,    16'h0004, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_AND, SZIN, 16'h0,    16'h0008, 5'b00101, 1, 0);
    add(1, 1, 1, 0, I_AND, SZL,  16'h0002, 16'h0,    5'b0,     1, 0);
    // mul
    fetch(I_MUL);
    add(1, 1, 1, 0, I_MUL, SYIN, 16'h0, 16'h0004, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_MUL, SZIN, 16'h0, 16'h0008, 5'b01111, 1, 0);
    add(1, 1, 1, 0, I_MUL, SZLO, 16'h0, 16'h0,    5'b0,     1, 0);
    add(1, 1, 1, 0, I_MUL, SZHI, 16'h0, 16'h0,    5'b0,     1, 0);
    // illegal
    fetch(I_ILL);
    add(1, 1, 1, 0, I_ILL, S0, 16'h0, 16'h0, 5'b0, 1, 1);
    // nop
    fetch(I_NOP);
    add(1, 1, 1, 0, I_NOP, S0, 16'h0, 16'h0, 5'b0, 1, 0);
    // not R4,R9 (unary reads Rb in T4)
    fetch(I_NOT);
    add(1, 1, 1, 0, I_NOT, SYIN, 16'h0,    16'h0200, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_NOT, SZIN, 16'h0,    16'h0200, 5'b10010, 1, 0);
    add(1, 1, 1, 0, I_NOT, SZL,  16'h0010, 16'h0,    5'b0,     1, 0);
    // div
    fetch(I_DIV);
    add(1, 1, 1, 0, I_DIV, SYIN, 16'h0, 16'h0002, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_DIV, SZIN, 16'h0, 16'h8000, 5'b10000, 1, 0);
    add(1, 1, 1, 0, I_DIV, SZLO, 16'h0, 16'h0,    5'b0,     1, 0);
    add(1, 1, 1, 0, I_DIV, SZHI, 16'h0, 16'h0,    5'b0,     1, 0);
    // or with stop raised in T4: write-back completes, then HALT
    fetch(I_OR);
    add(1, 1, 1, 0, I_OR, SYIN, 16'h0,    16'h0040, 5'b0,     1, 0);
    add(1, 1, 1, 1, I_OR, SZIN, 16'h0,    16'h0080, 5'b00110, 1, 0);
    add(1, 1, 1, 1, I_OR, SZL,  16'h0020, 16'h0,    5'b0,     1, 0);
    held(3, 1, 0);
    held(1, 0, 0);
    // halt instruction
    fetch(I_HALT);
    add(1, 1, 1, 0, I_HALT, S0, 16'h0, 16'h0, 5'b0, 1, 0);
    held(10, 1, 0);
    held(1, 0, 0);
    // clear mid-T4
    fetch(I_AND);
    add(1, 1, 1, 0, I_AND, SYIN, 16'h0, 16'h0004, 5'b0,     1, 0);
    add(1, 1, 1, 0, I_AND, SZIN, 16'h0, 16'h0008, 5'b00101, 1, 0);
    held(1, 0, 0);
    // clear during T1 memory wait
    add(1, 1, 0, 0, I_AND, ST0, 16'h0, 16'h0, 5'b0, 1, 0);
    add(2, 1, 0, 0, I_AND, ST1, 16'h0, 16'h0, 5'b0, 1, 0);
    held(1, 0, 0);
    // stop during nop's final T3
    fetch(I_NOP);
    add(1, 1, 1, 1, I_NOP, S0, 16'h0, 16'h0, 5'b0, 1, 0);
    held(2, 1, 0);
    held(1, 0, 0);

    #1;
    foreach (vq[i]) begin
      for (int unsigned k = 0; k < vq[i].n; k++) begin
        clear = vq[i].clr; bus.mem_ready = vq[i].mr;
        bus.stop = vq[i].stp; bus.ir = vq[i].ir;
        #1;
        check($sformatf("row%0d.%0d", i, k), 64'(outs()),
              64'({vq[i].strb, vq[i].rin, vq[i].rout, vq[i].opc, vq[i].run, vq[i].ill}));
        @(posedge Clock); #1;
      end
    end

    // State is T0 here (last row held clear low).
    run_count("and_wait3", I_AND, 3, 9, 4, 0);
    run_count("mul",       I_MUL, 0, 7, 1, 0);
    run_count("nop",       I_NOP, 0, 4, 1, 0);
    run_count("illegal",   I_ILL, 0, 4, 1, 1);
    run_count("and",       I_AND, 0, 6, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
